// File: rtl/mem_burst_writer.sv
// mem_burst_writer: drains the FWFT packing FIFO from the 8-to-32 burst
// up-converter and writes fixed-length bursts into the frame-buffer memory
// controller. It turns the byte-count/eof side bits into byte masks and
// frame-relative word addresses. A partial burst is flushed after the FIFO
// has sat non-empty, but below the burst threshold, for FLUSH_TIMEOUT cycles.
//
// Handshake rule used on both controller channels: a transfer happens on a
// clock edge where valid and ready are both high. Once valid is raised, valid
// and its payload stay unchanged until that edge. Valid never depends on
// ready.
module mem_burst_writer #(
    parameter int unsigned BURST_LEN     = 32,
    parameter int unsigned ADDR_W        = 21,
    parameter int unsigned BASE_ADDR     = 0,
    parameter int unsigned BUF_WORDS     = 65536,
    parameter int unsigned FLUSH_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              us_burst_avail,
    input  logic              us_empty,
    output logic              us_rd_en,
    input  logic [35:0]       us_rd_data,
    output logic              mem_cmd_vld_o,
    input  logic              mem_cmd_rdy_i,
    output logic [ADDR_W-1:0] mem_cmd_addr_o,
    output logic              mem_wdata_vld_o,
    input  logic              mem_wdata_rdy_i,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    output logic              frame_done_o
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam int unsigned TMO_W  = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ADDR_END  = (ADDR_W + 1)'(BASE_ADDR + BUF_WORDS);
    localparam logic [ADDR_W:0]   ADDR_STEP = (ADDR_W + 1)'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(FLUSH_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                pad_q, pad_d;
    logic                eof_seen_q, eof_seen_d;

    logic [ADDR_W:0]     addr_sum;
    logic                head_pad;
    logic [1:0]          head_be;
    logic                head_eof;

    // The reserved bit of the FIFO word carries nothing for this block.
    logic                unused_rsvd;
    assign unused_rsvd = us_rd_data[32];

    assign head_be        = us_rd_data[35:34];
    assign head_eof       = us_rd_data[33];
    assign mem_cmd_addr_o = addr_q;

    // State, address, counters and per-burst flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE;
            tmo_q      <= '0;
            beat_q     <= '0;
            pad_q      <= 1'b0;
            eof_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tmo_q      <= tmo_d;
            beat_q     <= beat_d;
            pad_q      <= pad_d;
            eof_seen_q <= eof_seen_d;
        end
    end

    // Next-state logic and all outputs. Data-phase outputs come straight from
    // the FIFO head, which stays put while the controller stalls.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        tmo_d           = tmo_q;
        beat_d          = beat_q;
        pad_d           = pad_q;
        eof_seen_d      = eof_seen_q;
        us_rd_en        = 1'b0;
        mem_cmd_vld_o   = 1'b0;
        mem_wdata_vld_o = 1'b0;
        mem_wdata_o     = '0;
        mem_wmask_o     = 4'hF;
        frame_done_o    = 1'b0;
        head_pad        = pad_q | us_empty;
        addr_sum        = {1'b0, addr_q} + ADDR_STEP;

        case (state_q)
            ST_IDLE: begin
                if (us_burst_avail) begin
                    tmo_d   = '0;
                    state_d = ST_CMD;
                end else if (us_empty) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    // Leftover words have waited long enough: flush a partial burst.
                    tmo_d   = '0;
                    state_d = ST_CMD;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_CMD: begin
                mem_cmd_vld_o = 1'b1;
                if (mem_cmd_rdy_i) begin
                    state_d    = ST_DATA;
                    beat_d     = '0;
                    pad_d      = 1'b0;
                    eof_seen_d = 1'b0;
                end
            end

            ST_DATA: begin
                mem_wdata_vld_o = 1'b1;
                if (!head_pad) begin
                    mem_wdata_o = us_rd_data[31:0];
                    case (head_be)
                        2'd3:    mem_wmask_o = 4'h0;
                        2'd2:    mem_wmask_o = 4'h8;
                        2'd1:    mem_wmask_o = 4'hC;
                        default: mem_wmask_o = 4'hE;
                    endcase
                    us_rd_en = mem_wdata_rdy_i;
                    if (mem_wdata_rdy_i && head_eof) begin
                        eof_seen_d = 1'b1;
                        pad_d      = 1'b1;
                    end
                end else if (us_empty) begin
                    // Padding must stay sticky once started, even while stalled,
                    // so a word that arrives late cannot replace a pad beat on
                    // the bus or land after a hole.
                    pad_d = 1'b1;
                end
                if (mem_wdata_rdy_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (eof_seen_q) begin
                    addr_d       = BASE;
                    frame_done_o = 1'b1;
                end else if (addr_sum >= ADDR_END) begin
                    addr_d = BASE;
                end else begin
                    addr_d = addr_sum[ADDR_W-1:0];
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
